// File: rtl/fir_tdm_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fir_tdm_ctrl                                               |
// | Description : Time-multiplexed FIR sequencer. One shared signed MAC      |
// |               walks N taps per accepted sample and emits one rounded,    |
// |               saturated output.                                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module fir_tdm_ctrl #(
  parameter int L  = 12,
  parameter int N  = 8,
  parameter int CW = 16,
  parameter int SH = 14,
  parameter int AW = L + CW + $clog2(N) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [$clog2(N)-1:0] cfg_addr,
  input  logic [CW-1:0]        cfg_data,
  input  logic [L-1:0]         x,
  input  logic                 x_valid,
  output logic                 x_ready,
  output logic [L-1:0]         y,
  output logic                 y_valid
);

  localparam int KW = $clog2(N);
  localparam int PW = L + CW;
  localparam logic [KW-1:0]        c_k_last = KW'(N - 1);
  localparam logic [CW-1:0]        c_unity  = CW'(2 ** SH);
  localparam logic signed [AW-1:0] c_round  = AW'(2 ** (SH - 1));
  localparam logic signed [AW-1:0] c_y_max  = {{(AW - L + 1){1'b0}}, {(L - 1){1'b1}}};
  localparam logic signed [AW-1:0] c_y_min  = {{(AW - L + 1){1'b1}}, {(L - 1){1'b0}}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MAC  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [KW-1:0]        wp_q, wp_d;
  logic [KW-1:0]        base_q, base_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [L-1:0]         hist_q [N];
  logic [L-1:0]         hist_d [N];
  logic [CW-1:0]        coef_q [N];
  logic [CW-1:0]        coef_d [N];
  logic [L-1:0]         y_q, y_d;
  logic                 y_valid_q, y_valid_d;
  logic                 x_ready_q, x_ready_d;

  logic [KW-1:0]        tap_idx;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] rounded;
  logic signed [AW-1:0] scaled;
  logic [L-1:0]         sat;

  always_comb begin
    // History is a power-of-two ring, so the subtraction wraps naturally.
    tap_idx = base_q - k_q;
    prod    = PW'($signed(coef_q[k_q])) * PW'($signed(hist_q[tap_idx]));
    sum     = acc_q + AW'(prod);
    rounded = sum + c_round;
    scaled  = rounded >>> SH;
    if (scaled > c_y_max) begin
      sat = c_y_max[L-1:0];
    end else if (scaled < c_y_min) begin
      sat = c_y_min[L-1:0];
    end else begin
      sat = scaled[L-1:0];
    end

    state_d   = state_q;
    k_d       = k_q;
    wp_d      = wp_q;
    base_d    = base_q;
    acc_d     = acc_q;
    hist_d    = hist_q;
    coef_d    = coef_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    x_ready_d = x_ready_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          coef_d[cfg_addr] = cfg_data;
        end
        if (x_valid) begin
          hist_d[wp_q] = x;
          base_d       = wp_q;
          wp_d         = wp_q + KW'(1);
          acc_d        = '0;
          k_d          = '0;
          x_ready_d    = 1'b0;
          state_d      = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = sum;
        k_d   = k_q + KW'(1);
        if (k_q == c_k_last) begin
          y_d       = sat;
          y_valid_d = 1'b1;
          x_ready_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        x_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      wp_q      <= '0;
      base_q    <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      x_ready_q <= 1'b1;
      for (int i = 0; i < N; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= (i == 0) ? c_unity : '0;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      wp_q      <= wp_d;
      base_q    <= base_d;
      acc_q     <= acc_d;
      hist_q    <= hist_d;
      coef_q    <= coef_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      x_ready_q <= x_ready_d;
    end
  end

  assign x_ready = x_ready_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_tdm_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fir_tdm_ctrl                                            |
// | Description : Self-checking bench for fir_tdm_ctrl: directed vector      |
// |               table, multi-cycle corner sequences, randomized traffic.   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_fir_tdm_ctrl;

  localparam int L  = 12;
  localparam int N  = 8;
  localparam int CW = 16;
  localparam int SH = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_addr = '0;
  logic [CW-1:0] cfg_data = '0;
  logic [L-1:0]  x = '0;
  logic          x_valid = 1'b0;
  logic          x_ready;
  logic [L-1:0]  y;
  logic          y_valid;

  fir_tdm_ctrl #(.L(L), .N(N), .CW(CW), .SH(SH)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .x        (x),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .y        (y),
    .y_valid  (y_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain integer convolution over the last N samples.
  int mc [N];
  int mh [N];
  int mwp;

  function automatic int s12(input logic [11:0] v);
    return int'($signed(v));
  endfunction

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mc[i] = 0;
      mh[i] = 0;
    end
    mc[0] = 2 ** SH;
    mwp   = 0;
  endfunction

  function automatic int model_push(input int xv);
    longint acc;
    int     base;
    mh[mwp] = xv;
    base    = mwp;
    mwp     = (mwp + 1) % N;
    acc     = 0;
    for (int k = 0; k < N; k++) begin
      acc += longint'(mc[k]) * longint'(mh[(base - k + N) % N]);
    end
    acc = (acc + (64'sd1 <<< (SH - 1))) >>> SH;
    if (acc > 2047)  acc = 2047;
    if (acc < -2048) acc = -2048;
    return int'(acc);
  endfunction

  task automatic apply_reset();
    rst     = 1'b0;
    x_valid = 1'b0;
    cfg_we  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    mc[a]  = s16(d);
  endtask

  // Entered and left on a falling edge; leaves with y_valid high.
  task automatic do_sample(input logic [11:0] xv, input logic we, input logic [2:0] a,
                           input logic [15:0] d, output int yv, output int ym,
                           output int lat, output logic busy_ok);
    int t;
    t = 0;
    while (!x_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (!x_ready) check("x_ready_timeout", 0, 1);
    x        = xv;
    x_valid  = 1'b1;
    cfg_we   = we;
    cfg_addr = a;
    cfg_data = d;
    if (we) mc[a] = s16(d);
    ym = model_push(s12(xv));
    @(negedge clk);
    x_valid = 1'b0;
    cfg_we  = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (!y_valid && lat < 64) begin
      if (x_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!y_valid) check("y_valid_timeout", 0, 1);
    yv = s12(y);
  endtask

  typedef struct {
    int grp;
    int xin;
    int yexp;
  } vec_t;

  vec_t tbl [25];

  task automatic setup_group(input int g);
    apply_reset();
    case (g)
      1: for (int k = 0; k < N; k++) cfg_write(3'(k), 16'd2048);
      2: begin
        cfg_write(3'd0, 16'd32767);
        cfg_write(3'd1, 16'd32767);
      end
      3: begin
        cfg_write(3'd0, 16'd0);
        cfg_write(3'd7, 16'd16384);
      end
      default: ;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   yv, ym, lat, prev_grp, t;
    logic busy_ok, saw;

    // grp 0: passthrough, 1: moving average, 2: saturation, 3: wrap-around
    tbl[0]  = '{0, 1281, 1281};
    tbl[1]  = '{0, -170, -170};
    tbl[2]  = '{0, 4095, -1};
    tbl[3]  = '{1, 2047, 256};
    tbl[4]  = '{1, 2047, 512};
    tbl[5]  = '{1, 2047, 768};
    tbl[6]  = '{1, 2047, 1024};
    tbl[7]  = '{1, 2047, 1279};
    tbl[8]  = '{1, 2047, 1535};
    tbl[9]  = '{1, 2047, 1791};
    tbl[10] = '{1, 2047, 2047};
    tbl[11] = '{2, 2047, 2047};
    tbl[12] = '{2, 2047, 2047};
    tbl[13] = '{2, -2048, -2};
    tbl[14] = '{2, -2048, -2048};
    for (int i = 0; i < 10; i++) tbl[15 + i] = '{3, i + 1, (i < 7) ? 0 : i - 6};

    @(negedge clk);
    check("reset_x_ready", int'(x_ready), 1);
    check("reset_y", s12(y), 0);
    check("reset_y_valid", int'(y_valid), 0);

    prev_grp = -1;
    for (int i = 0; i < 25; i++) begin
      if (tbl[i].grp != prev_grp) setup_group(tbl[i].grp);
      prev_grp = tbl[i].grp;
      do_sample(12'(tbl[i].xin), 1'b0, 3'd0, 16'd0, yv, ym, lat, busy_ok);
      check($sformatf("vec%0d_y", i), yv, tbl[i].yexp);
      check($sformatf("vec%0d_latency", i), lat, N);
      if (tbl[i].grp == 0) check($sformatf("vec%0d_busy_ready_low", i), int'(busy_ok), 1);
    end

    // Strobe lasts one cycle and y holds afterwards.
    @(negedge clk);
    check("y_valid_one_cycle", int'(y_valid), 0);
    repeat (3) @(negedge clk);
    check("y_hold", s12(y), 3);

    // Coefficient write while busy is dropped.
    apply_reset();
    x       = 12'd5;
    x_valid = 1'b1;
    ym      = model_push(5);
    @(negedge clk);
    x_valid  = 1'b0;
    cfg_we   = 1'b1;
    cfg_addr = 3'd0;
    cfg_data = 16'd0;
    @(negedge clk);
    cfg_we = 1'b0;
    t = 0;
    while (!y_valid && t < 64) begin
      @(negedge clk);
      t++;
    end
    check("busy_write_first_y_valid", int'(y_valid), 1);
    check("busy_write_first_y", s12(y), 5);
    do_sample(12'd300, 1'b0, 3'd0, 16'd0, yv, ym, lat, busy_ok);
    check("busy_write_next_y", yv, 300);

    // Write and accept in the same cycle.
    apply_reset();
    do_sample(12'd2000, 1'b1, 3'd0, 16'd8192, yv, ym, lat, busy_ok);
    check("simul_write_y", yv, 1000);

    // Reset mid-MAC.
    apply_reset();
    do_sample(12'd999, 1'b0, 3'd0, 16'd0, yv, ym, lat, busy_ok);
    check("pre_abort_y", yv, 999);
    @(negedge clk);
    x       = 12'd1000;
    x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_x_ready", int'(x_ready), 1);
    check("abort_y", s12(y), 0);
    check("abort_y_valid", int'(y_valid), 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (y_valid) saw = 1'b1;
    end
    check("abort_no_y_valid", int'(saw), 0);
    do_sample(12'd676, 1'b0, 3'd0, 16'd0, yv, ym, lat, busy_ok);
    check("post_abort_y", yv, 676);

    // Randomized traffic against the model.
    apply_reset();
    for (int i = 0; i < 150; i++) begin
      logic [15:0] cd;
      cd = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 65535))
                                       : 16'($signed(12'($urandom_range(0, 4095))));
      if ($urandom_range(0, 3) == 0) cfg_write(3'($urandom_range(0, 7)), cd);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_sample(12'($urandom_range(0, 4095)), ($urandom_range(0, 7) == 0),
                3'($urandom_range(0, 7)), cd, yv, ym, lat, busy_ok);
      check($sformatf("rand%0d_y", i), yv, ym);
      check($sformatf("rand%0d_latency", i), lat, N);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
